// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared N-bit ALU
// (MOV/ADD/SUB/AND/ORR/EOR with NZCV); the result is held until its owner takes it.
//
// state  | meaning
// S_IDLE | waiting for a request; grant driven combinationally from valids
// S_EXEC | captured operands go through the ALU; result/flags registered
// S_RESP | result offered to the owner until its rsp ready
module alu_share_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t       state_q, state_d;
  logic         last_q, last_d;
  logic         owner_q, owner_d;
  logic [2:0]   op_q, op_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;

  logic         gnt0, gnt1;
  logic [N:0]   sum;
  logic [N-1:0] alu_res;
  logic         alu_c, alu_v;

  // last_q holds the previous winner; on a tie the other requester wins
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  always_comb begin
    sum     = '0;
    alu_res = a_q;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      3'b001: begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (a_q[N-1] == b_q[N-1]) && (alu_res[N-1] != a_q[N-1]);
      end
      3'b010: begin
        // carry out of a + ~b + 1 is the no-borrow flag
        sum     = {1'b0, a_q} + {1'b0, ~b_q} + {{N{1'b0}}, 1'b1};
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (a_q[N-1] != b_q[N-1]) && (alu_res[N-1] != a_q[N-1]);
      end
      3'b011:  alu_res = a_q & b_q;
      3'b100:  alu_res = a_q | b_q;
      3'b101:  alu_res = a_q ^ b_q;
      default: alu_res = a_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    flags_d    = flags_q;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt0 || gnt1) begin
          owner_d = gnt1;
          last_d  = gnt1;
          op_d    = gnt1 ? req1_op : req0_op;
          a_d     = gnt1 ? req1_a  : req0_a;
          b_d     = gnt1 ? req1_b  : req0_b;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_res;
        flags_d  = {alu_res[N-1], (alu_res == '0), alu_c, alu_v};
        state_d  = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed boundary vectors, round robin, backpressure,
// mid-operation reset, then random traffic against a transaction-level model.
module tb_alu_share_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;

  always #5 clk = ~clk;

  alu_share_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // transaction model: stage 0 = free, 1 = computing, 2 = offering result
  int          m_stage;
  bit          m_last, m_owner;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_flg;
  bit          pend0, pend1;
  int          gq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [35:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, full, sres;
    logic [31:0] r;
    bit c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd1: begin
        full = longint'(a) + longint'(b);
        r    = full[31:0];
        c    = (full >= 64'h1_0000_0000);
        sres = sa + sb;
        v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      3'd2: begin
        r    = a - b;
        c    = (a >= b);
        sres = sa - sb;
        v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      3'd3:    r = a & b;
      3'd4:    r = a | b;
      3'd5:    r = a ^ b;
      default: r = a;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic int m_grant();
    if (m_stage != 0) return -1;
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic m_reset();
    m_stage = 0; m_last = 1'b1; m_owner = 1'b0;
    m_res = '0; m_flg = '0; pend0 = 0; pend1 = 0;
  endtask

  // called at negedge with inputs already driven; checks, then advances model
  task automatic step();
    int g;
    #1;
    g = m_grant();
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    chk("busy", busy, m_stage != 0);
    chk("rsp0_valid", rsp0_valid, (m_stage == 2) && !m_owner);
    chk("rsp1_valid", rsp1_valid, (m_stage == 2) && m_owner);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_flags", rsp_flags, m_flg);
    @(posedge clk);
    case (m_stage)
      0: if (g >= 0) begin
        m_op    = (g == 1) ? req1_op : req0_op;
        m_a     = (g == 1) ? req1_a  : req0_a;
        m_b     = (g == 1) ? req1_b  : req0_b;
        m_owner = (g == 1);
        m_last  = (g == 1);
        m_stage = 1;
        if (g == 1) pend1 = 0; else pend0 = 0;
      end
      1: begin
        {m_flg, m_res} = ref_alu(m_op, m_a, m_b);
        m_stage = 2;
      end
      default: if (m_owner ? rsp1_ready : rsp0_ready) m_stage = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
    req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    req1_valid = 0; rsp0_ready = 1;
    step();
    req0_valid = 0;
    req0_a = ~a;
    step();
    #1;
    chk({tag, "_valid"}, rsp0_valid, 1'b1);
    chk({tag, "_res"}, rsp_result, er);
    chk({tag, "_flags"}, rsp_flags, ef);
    step();
  endtask

  task automatic mid_reset(input string tag);
    #1 rst_n = 0;
    #1;
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rsp0v"}, rsp0_valid, 1'b0);
    chk({tag, "_rsp1v"}, rsp1_valid, 1'b0);
    chk({tag, "_res"}, rsp_result, 32'h0);
    chk({tag, "_flags"}, rsp_flags, 4'h0);
    m_reset();
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    m_reset();
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp0v", rsp0_valid, 1'b0);
    chk("rst_rsp1v", rsp1_valid, 1'b0);
    chk("rst_res", rsp_result, 32'h0);
    chk("rst_flags", rsp_flags, 4'h0);
    @(negedge clk);
    rst_n = 1;

    directed("mov",      3'd0, 32'hDEAD_BEEF, 32'h1234, 32'hDEAD_BEEF, 4'b1000);
    directed("add_ovf",  3'd1, 32'h7FFF_FFFF, 32'h1,    32'h8000_0000, 4'b1001);
    directed("add_wrap", 3'd1, 32'hFFFF_FFFF, 32'h1,    32'h0000_0000, 4'b0110);
    directed("sub_eq",   3'd2, 32'd5,         32'd5,    32'h0000_0000, 4'b0110);
    directed("sub_neg",  3'd2, 32'd3,         32'd5,    32'hFFFF_FFFE, 4'b1000);
    directed("sub_ovf",  3'd2, 32'h8000_0000, 32'h1,    32'h7FFF_FFFF, 4'b0011);
    directed("rsvd_mov", 3'd7, 32'h0F0F_0000, 32'hFF,   32'h0F0F_0000, 4'b0000);

    // round robin after a fresh reset
    mid_reset("rr_rst");
    rsp0_ready = 1; rsp1_ready = 1;
    gq.delete();
    for (int i = 0; i < 12; i++) begin
      req0_valid = 1; req1_valid = 1;
      req0_op = 3'($urandom_range(0, 7)); req0_a = rnd_opnd(); req0_b = rnd_opnd();
      req1_op = 3'($urandom_range(0, 7)); req1_a = rnd_opnd(); req1_b = rnd_opnd();
      #1;
      if (req0_ready) gq.push_back(0);
      else if (req1_ready) gq.push_back(1);
      step();
    end
    chk("rr_count", gq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gq.size()) chk("rr_order", gq[i], i % 2);

    // backpressure on requester 1 while requester 0 waits
    req0_valid = 0; req1_valid = 1; req1_op = 3'd1;
    req1_a = 32'h1234_5678; req1_b = 32'h0101_0101; rsp1_ready = 0;
    step();
    req1_valid = 0; req0_valid = 1; req0_op = 3'd5; req0_a = 32'hA5A5; req0_b = 32'h5A5A;
    step();
    for (int i = 0; i < 10; i++) begin
      rsp0_ready = 1'($urandom_range(0, 1));
      step();
    end
    rsp1_ready = 1;
    step();
    #1 chk("bp_req0_granted", req0_ready, 1'b1);
    step();
    req0_valid = 0; rsp0_ready = 1;
    repeat (2) step();

    // reset during EXEC, then during RESP
    req0_valid = 1; req0_op = 3'd0; req0_a = 32'hDEAD_BEEF; req0_b = 0; rsp0_ready = 0;
    step();
    req0_valid = 0;
    mid_reset("rst_exec");
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("rst_exec_tie0", req0_ready, 1'b1);
    chk("rst_exec_tie1", req1_ready, 1'b0);
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (2) step();
    mid_reset("rst_resp");
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("rst_resp_tie0", req0_ready, 1'b1);
    chk("rst_resp_tie1", req1_ready, 1'b0);
    step();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (3) step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (!pend0 && $urandom_range(0, 2) == 0) pend0 = 1;
      if (!pend1 && $urandom_range(0, 2) == 0) pend1 = 1;
      req0_valid = pend0; req1_valid = pend1;
      req0_op = 3'($urandom_range(0, 7)); req0_a = rnd_opnd(); req0_b = rnd_opnd();
      req1_op = 3'($urandom_range(0, 7)); req1_a = rnd_opnd(); req1_b = rnd_opnd();
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
